// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer controller.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_BIT   = 1'b0;

  // Width of the bit counter for an n-bit word (holds 0..n-1, at least 1 bit).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx_ctrl_shreg.sv
// N-bit parallel-in / serial-out left-shift register, zero fill, MSB out.
module piso_shreg
  import piso_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         ld,
  input  logic [N-1:0] d,
  output logic         msb
);

  logic [N-1:0] q;

  // Load a new word, or shift left by one with a zero entering the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {N{RST_BIT}};
    end else if (en) begin
      q <= ld ? d : {q[N-2:0], 1'b0};
    end
  end

  assign msb = q[N-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serializer controller: accepts a word over valid/ready, shifts it out
// MSB-first at div+1 clocks per bit, framed by frame/bit_stb/done.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high unless abort
// SHIFT | frame active, bits going out on sout
// GAP   | one cycle after the last bit; done pulses here
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int N     = 8,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             abort,
  output logic             sout,
  output logic             frame,
  output logic             bit_stb,
  output logic             done,
  output logic             busy
);

  localparam int            CW       = cnt_w(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic             accept;
  logic             step;
  logic             kill;
  logic             sh_en;
  logic             sh_ld;
  logic             sh_msb;
  logic [N-1:0]     sh_d;

  assign in_ready = (state == IDLE) & ~abort;
  assign accept   = in_valid & in_ready;
  assign kill     = abort & (state != IDLE);
  assign step     = (state == SHIFT) & ~abort & (div_cnt == '0) & (bit_cnt != '0);

  // Accept and kill are mutually exclusive; kill reloads zeros to clear the word.
  assign sh_en = accept | step | kill;
  assign sh_ld = accept | kill;
  assign sh_d  = kill ? '0 : in_data;
  assign sout  = sh_msb & frame;

  piso_shreg #(.N(N)) u_shreg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sh_en),
    .ld    (sh_ld),
    .d     (sh_d),
    .msb   (sh_msb)
  );

  // Sequencer: state, bit/divider counters and registered framing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      bit_cnt <= '0;
      div_cnt <= '0;
      div_q   <= '0;
      frame   <= RST_BIT;
      bit_stb <= RST_BIT;
      done    <= RST_BIT;
      busy    <= RST_BIT;
    end else begin
      bit_stb <= 1'b0;
      done    <= 1'b0;
      if (kill) begin
        state <= IDLE;
        frame <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state   <= SHIFT;
              div_q   <= div;
              div_cnt <= div;
              bit_cnt <= LAST_BIT;
              frame   <= 1'b1;
              bit_stb <= 1'b1;
              busy    <= 1'b1;
            end
          end
          SHIFT: begin
            if (div_cnt != '0) begin
              div_cnt <= div_cnt - 1'b1;
            end else if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - 1'b1;
              div_cnt <= div_q;
              bit_stb <= 1'b1;
            end else begin
              state <= GAP;
              frame <= 1'b0;
              done  <= 1'b1;
            end
          end
          GAP: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            frame <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Self-checking bench for piso_tx_ctrl against a per-cycle frame model.
module tb_piso_tx_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] div;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       abort;
  logic       sout, frame, bit_stb, done, busy;

  int checks = 0;
  int errors = 0;

  // captured frame trace
  logic cap_sout[$];
  logic cap_stb[$];
  int   cap_rdy;
  logic gap_frame, gap_done, gap_busy, gap_ready, gap_sout;
  logic post_done, post_busy, post_ready;

  piso_tx_ctrl #(.N(N), .DIV_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div      (div),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .abort    (abort),
    .sout     (sout),
    .frame    (frame),
    .bit_stb  (bit_stb),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Offer a word until accepted, then record every frame cycle plus two after.
  task automatic capture(input logic [7:0] data, input logic [7:0] d, input logic [7:0] d_after);
    int n;
    cap_sout.delete();
    cap_stb.delete();
    cap_rdy = 0;
    @(negedge clk);
    in_data = data; div = d; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0; div = d_after; in_data = 8'($urandom);
    n = 0;
    while (frame === 1'b1 && n < 600) begin
      cap_sout.push_back(sout);
      cap_stb.push_back(bit_stb);
      if (in_ready === 1'b1) cap_rdy++;
      @(negedge clk);
      n++;
    end
    gap_frame = frame; gap_done = done; gap_busy = busy; gap_ready = in_ready; gap_sout = sout;
    @(negedge clk);
    post_done = done; post_busy = busy; post_ready = in_ready;
  endtask

  task automatic drain(output int dn, output bit to);
    int n = 0;
    dn = 0; to = 1'b0;
    while (busy !== 1'b0 && n < 600) begin
      if (done === 1'b1) dn++;
      @(negedge clk);
      n++;
    end
    if (n >= 600) to = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; div = '0; in_data = '0;
    #12;
    checks++; if ({frame, sout, bit_stb, done, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_outs got %b exp 00000", {frame, sout, bit_stb, done, busy});
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b exp 1", in_ready); end
    checks++; if ({frame, sout, done, busy} !== 4'b0) begin
      errors++; $display("FAIL idle_outs got %b exp 0000", {frame, sout, done, busy});
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] data, input logic [7:0] d,
                            input logic [7:0] d_after);
    int per, exp_len, len;
    logic eb, es;
    capture(data, d, d_after);
    per = int'(d) + 1;
    exp_len = N * per;
    len = cap_sout.size();
    checks++; if (len != exp_len) begin
      errors++; $display("FAIL %s frame_len got %0d exp %0d", name, len, exp_len);
    end
    for (int i = 0; i < len && i < exp_len; i++) begin
      eb = data[N - 1 - i / per];
      es = (i % per) == 0;
      checks++; if (cap_sout[i] !== eb) begin
        errors++; $display("FAIL %s sout[%0d] got %b exp %b", name, i, cap_sout[i], eb);
      end
      checks++; if (cap_stb[i] !== es) begin
        errors++; $display("FAIL %s bit_stb[%0d] got %b exp %b", name, i, cap_stb[i], es);
      end
    end
    checks++; if (cap_rdy != 0) begin
      errors++; $display("FAIL %s ready_in_frame got %0d exp 0", name, cap_rdy);
    end
    checks++; if ({gap_frame, gap_sout, gap_done, gap_busy, gap_ready} !== 5'b00110) begin
      errors++; $display("FAIL %s gap fr/so/dn/bs/rd got %b exp 00110", name,
                         {gap_frame, gap_sout, gap_done, gap_busy, gap_ready});
    end
    checks++; if ({post_done, post_busy, post_ready} !== 3'b001) begin
      errors++; $display("FAIL %s post dn/bs/rd got %b exp 001", name, {post_done, post_busy, post_ready});
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] d, input logic [7:0] w0, input logic [7:0] w1);
    int per, flen, n;
    logic fr[$], rd[$], so[$];
    logic ef, er, es;
    per = int'(d) + 1;
    flen = N * per;
    @(negedge clk);
    div = d; in_data = w0; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 2 * flen + 4; i++) begin
      @(negedge clk);
      if (i == 0) in_data = w1;
      fr.push_back(frame); rd.push_back(in_ready); so.push_back(sout);
      if (i == flen + 2) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 2 * flen + 4; i++) begin
      ef = (i < flen) || (i >= flen + 2 && i < 2 * flen + 2);
      er = (i == flen + 1) || (i >= 2 * flen + 3);
      if (i < flen) es = w0[N - 1 - i / per];
      else if (i >= flen + 2 && i < 2 * flen + 2) es = w1[N - 1 - (i - flen - 2) / per];
      else es = 1'b0;
      checks++; if ({fr[i], rd[i], so[i]} !== {ef, er, es}) begin
        errors++; $display("FAIL b2b cyc %0d fr/rd/so got %b exp %b", i, {fr[i], rd[i], so[i]}, {ef, er, es});
      end
    end
  endtask

  task automatic test_abort(input logic [7:0] d, input logic [7:0] w, input logic [7:0] nw);
    int per, n, dn;
    bit to;
    per = int'(d) + 1;
    @(negedge clk);
    div = d; in_data = w; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 3 * per; i++) @(negedge clk);
    checks++; if ({frame, bit_stb, sout} !== {2'b11, w[N - 4]}) begin
      errors++; $display("FAIL abort_bit3 fr/stb/so got %b exp %b", {frame, bit_stb, sout}, {2'b11, w[N - 4]});
    end
    abort = 1'b1; in_valid = 1'b1; in_data = nw;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if ({frame, sout, done, busy, bit_stb} !== 5'b0) begin
      errors++; $display("FAIL abort_after fr/so/dn/bs/stb got %b exp 00000", {frame, sout, done, busy, bit_stb});
    end
    abort = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_back got %b exp 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({frame, bit_stb, busy, sout} !== {3'b111, nw[N - 1]}) begin
      errors++; $display("FAIL abort_next_accept got %b exp %b", {frame, bit_stb, busy, sout}, {3'b111, nw[N - 1]});
    end
    drain(dn, to);
    checks++; if (to || dn != 1) begin
      errors++; $display("FAIL abort_next_done got %0d timeout %0d exp 1 0", dn, to);
    end
  endtask

  task automatic test_idle_abort;
    int dn;
    bit to;
    @(negedge clk);
    abort = 1'b1; in_valid = 1'b1; in_data = 8'h3C; div = 8'd0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_abort_ready got %b exp 0", in_ready); end
    @(negedge clk);
    checks++; if ({frame, busy} !== 2'b00) begin
      errors++; $display("FAIL idle_abort_accepted got %b exp 00", {frame, busy});
    end
    abort = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if ({frame, sout} !== 2'b10) begin
      errors++; $display("FAIL idle_abort_then_accept got %b exp 10", {frame, sout});
    end
    drain(dn, to);
    checks++; if (to || dn != 1) begin
      errors++; $display("FAIL idle_abort_done got %0d timeout %0d exp 1 0", dn, to);
    end
  endtask

  task automatic test_reset_mid_frame(input logic [7:0] d);
    int per, n;
    per = int'(d) + 1;
    @(negedge clk);
    div = d; in_data = 8'hFF; in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); in_valid = 1'b0;
    for (int i = 0; i < 5 * per; i++) @(negedge clk);
    checks++; if ({frame, bit_stb, sout} !== 3'b111) begin
      errors++; $display("FAIL rst_bit5_pre got %b exp 111", {frame, bit_stb, sout});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({frame, sout, bit_stb, done, busy} !== 5'b0) begin
      errors++; $display("FAIL rst_async got %b exp 00000", {frame, sout, bit_stb, done, busy});
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if ({frame, done, busy, in_ready} !== 4'b0001) begin
        errors++; $display("FAIL rst_stay_idle[%0d] got %b exp 0001", i, {frame, done, busy, in_ready});
      end
    end
  endtask

  initial begin
    logic [7:0] rd, rw0, rw1;
    test_reset();
    test_frame("single_a5", 8'hA5, 8'd0, 8'd0);
    test_frame("div3_81", 8'h81, 8'd3, 8'd3);
    test_frame("div_change", 8'($urandom), 8'd1, 8'd7);
    test_back_to_back(8'd0, 8'hFF, 8'h00);
    rd = 8'($urandom_range(1, 3)); rw0 = 8'($urandom); rw1 = 8'($urandom);
    test_back_to_back(rd, rw0, rw1);
    test_abort(8'd0, 8'hF0, 8'($urandom));
    test_abort(8'd2, 8'hF0, 8'($urandom));
    test_idle_abort();
    for (int k = 0; k < 6; k++) begin
      test_frame("random", 8'($urandom), 8'($urandom_range(0, 5)), 8'($urandom));
    end
    test_reset_mid_frame(8'd0);
    test_reset_mid_frame(8'd2);
    test_frame("after_reset", 8'h5A, 8'd1, 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
